split_addsub_pipe: RTL and testbench

SPLIT_ADDSUB_PIPE -- requirements
Module: split_addsub_pipe

---
 rtl/split_addsub_pipe.sv | 79 +++++++
 tb/tb_split_addsub_pipe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/split_addsub_pipe.sv
// split_addsub_pipe: two-stage segmented carry-select adder/subtractor with valid/ready handshake.
// Define SPLIT_ADDSUB_SUB_EN to make the sub port select A - B; otherwise sub is ignored.
module split_addsub_pipe #(
  parameter int IO = 512,
  parameter int SS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IO-1:0] a,
  input  logic [IO-1:0] b,
  input  logic          cin,
  input  logic          sub,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [IO-1:0] sum,
  output logic          overflow,
  output logic          out_valid,
  input  logic          out_ready
);
  localparam int N_PARTS = (IO + SS - 1) / SS;
  logic [IO-1:0] bx, p0_d, p1_d, ps0, ps1, sum_d;
  logic [N_PARTS-1:0] c0_d, c1_d, co0, co1;
  logic [N_PARTS:0] sel;
  logic cin1, v1, v2, ld1, ld2;
`ifdef SPLIT_ADDSUB_SUB_EN
  assign bx = sub ? ~b : b;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign bx = b;
`endif
  assign ld2 = ~v2 | out_ready;
  assign ld1 = ~v1 | ld2;
  assign in_ready = ld1;
  assign out_valid = v2;
  // Each segment precomputes both carry-in outcomes; the last one may be narrower than SS.
  for (genvar j = 0; j < N_PARTS; j++) begin : g_seg
    localparam int LO = j * SS;
    localparam int W = (j == N_PARTS - 1) ? IO - LO : SS;
    logic [W:0] s0, s1;
    assign s0 = {1'b0, a[LO+:W]} + {1'b0, bx[LO+:W]};
    assign s1 = s0 + (W+1)'(1);
    assign p0_d[LO+:W] = s0[W-1:0];
    assign p1_d[LO+:W] = s1[W-1:0];
    assign c0_d[j] = s0[W];
    assign c1_d[j] = s1[W];
  end
  always_comb begin
    sel = '0;
    sel[0] = cin1;
    for (int j = 0; j < N_PARTS; j++) sel[j+1] = sel[j] ? co1[j] : co0[j];
    sum_d = ps0;
    for (int i = 0; i < IO; i++) sum_d[i] = sel[i/SS] ? ps1[i] : ps0[i];
  end
  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      ps0 <= p0_d;
      ps1 <= p1_d;
      co0 <= c0_d;
      co1 <= c1_d;
      cin1 <= cin;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      sum <= '0;
      overflow <= 1'b0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld2 && v1) begin
        sum <= sum_d;
        overflow <= sel[N_PARTS];
      end
    end
  end
endmodule

// File: tb/tb_split_addsub_pipe.sv
// tb_split_addsub_pipe: scoreboard bench for a 10-bit (partial last segment) and a 512-bit instance.
module tb_split_addsub_pipe;
  localparam int IO = 10, SS = 4, WW = 512;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [IO-1:0] a, b, sum;
  logic cin, sub, in_valid, in_ready, overflow, out_valid, out_ready;
  logic [WW-1:0] aw, bw, sum_w;
  logic in_ready_w, ovf_w, out_valid_w;
  logic [IO:0] exp_in;
  logic [IO:0] q[$];
  logic [WW:0] qw[$];
  int tests = 0, fails = 0;

  split_addsub_pipe #(.IO(IO), .SS(SS)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sub(sub), .in_valid(in_valid),
    .in_ready(in_ready), .sum(sum), .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready));
  split_addsub_pipe #(.IO(WW), .SS(4)) dut_w (
    .clk(clk), .rst(rst), .a(aw), .b(bw), .cin(cin), .sub(1'b0), .in_valid(in_valid),
    .in_ready(in_ready_w), .sum(sum_w), .overflow(ovf_w), .out_valid(out_valid_w), .out_ready(out_ready));

`ifdef SPLIT_ADDSUB_SUB_EN
  localparam logic [IO:0] E1 = 11'h3FE, E2 = 11'h407, E3 = 11'h3FF;
`else
  localparam logic [IO:0] E1 = 11'h00D, E2 = 11'h00E, E3 = 11'h002;
`endif
  logic [IO-1:0] da [10] = '{10'h3FF, 10'h005, 10'h000, 10'h2AA, 10'h3FF, 10'h00F, 10'h0FF, 10'h300, 10'h00A, 10'h000};
  logic [IO-1:0] db [10] = '{10'h001, 10'h007, 10'h000, 10'h155, 10'h3FF, 10'h001, 10'h001, 10'h100, 10'h003, 10'h001};
  logic dc [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic ds [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [IO:0] de [10] = '{11'h400, E1, 11'h001, 11'h3FF, 11'h7FF, 11'h010, 11'h100, 11'h400, E2, E3};
  logic [IO-1:0] ba [3] = '{10'h123, 10'h200, 10'h0F0};
  logic [IO-1:0] bb [3] = '{10'h001, 10'h200, 10'h00F};
  logic bc [3] = '{1'b0, 1'b0, 1'b1};
  logic [IO:0] be [3] = '{11'h124, 11'h400, 11'h100};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IO:0] ref10(input logic [IO-1:0] x, input logic [IO-1:0] y, input logic c, input logic s);
    logic [IO-1:0] yy;
    yy = y;
`ifdef SPLIT_ADDSUB_SUB_EN
    if (s) yy = ~y;
`else
    if (s) yy = y;
`endif
    return {1'b0, x} + {1'b0, yy} + (IO+1)'(c);
  endfunction

  logic stall = 0;
  logic [IO:0] held = '0;
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      qw.delete();
      stall <= 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {overflow, sum}, held);
      end
      stall <= out_valid && !out_ready;
      held <= {overflow, sum};
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out: got %0h expected no output", {overflow, sum});
        end else chk("result", {overflow, sum}, q.pop_front());
      end
      if (out_valid_w && out_ready) begin
        tests++;
        if (qw.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out_w: got %0h expected no output", {ovf_w, sum_w});
        end else if ({ovf_w, sum_w} !== qw[0]) begin
          fails++;
          $display("FAIL result_w: got %0h expected %0h", {ovf_w, sum_w}, qw[0]);
          void'(qw.pop_front());
        end else void'(qw.pop_front());
      end
      if (in_valid && in_ready) q.push_back(exp_in);
      if (in_valid && in_ready_w) qw.push_back({1'b0, aw} + {1'b0, bw} + (WW+1)'(cin));
    end
  end

  task automatic send(input logic [IO-1:0] ta, input logic [IO-1:0] tb_, input logic tc, input logic ts, input logic [IO:0] te);
    logic ok;
    a = ta; b = tb_; cin = tc; sub = ts; exp_in = te; in_valid = 1;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk("send_accept", ok, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && (q.size() != 0 || qw.size() != 0); k++) @(posedge clk);
    #1;
    chk("drain", q.size() + qw.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, idx;
    logic took;
    a = 0; b = 0; cin = 0; sub = 0; in_valid = 0; out_ready = 1; aw = '0; bw = '0; exp_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_overflow", overflow, 0);
    for (int i = 0; i < 10; i++) send(da[i], db[i], dc[i], ds[i], de[i]);
    drain();
    // backpressure: only two operands fit while the output is stalled
    out_ready = 0; acc = 0; idx = 0;
    a = ba[0]; b = bb[0]; cin = bc[0]; sub = 0; exp_in = be[0]; in_valid = 1;
    repeat (5) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
      if (took) begin
        acc++;
        idx++;
        if (idx < 3) begin a = ba[idx]; b = bb[idx]; cin = bc[idx]; exp_in = be[idx]; end
      end
    end
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1;
    send(ba[2], bb[2], bc[2], 1'b0, be[2]);
    drain();
    // reset with two results in flight
    out_ready = 0;
    send(10'h111, 10'h111, 1'b0, 1'b0, 11'h222);
    send(10'h0AA, 10'h055, 1'b0, 1'b0, 11'h0FF);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_sum", sum, 0);
    out_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("flush_quiet", out_valid, 0);
    // back-to-back random stream on both widths
    for (int i = 0; i < 200; i++) begin
      a = IO'($urandom); b = IO'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      for (int w = 0; w < WW / 32; w++) begin
        aw[w*32+:32] = $urandom;
        bw[w*32+:32] = $urandom;
      end
      exp_in = ref10(a, b, cin, sub);
      in_valid = 1;
      chk("stream_in_ready", in_ready, 1);
      if (i >= 2) begin
        chk("stream_out_valid", out_valid, 1);
        chk("stream_out_valid_w", out_valid_w, 1);
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
